// File: rtl/piso_pkg.sv
// Shared types and constants for the PISO transmitter: FSM state encoding,
// default word width and the bit-counter width helper.
package piso_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // A one-bit counter is still needed for the 2-bit word case.
  function automatic int cnt_width(input int data_width);
    return (data_width <= 2) ? 1 : $clog2(data_width);
  endfunction

endpackage

// File: rtl/parallel_in_serial_out_piso_tx_if.sv
// Parallel word handshake and serial frame signals of the PISO transmitter.
// The master modport is the word producer / stream consumer side.
interface parallel_in_serial_out_piso_tx_if
  import piso_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] Parallel_Data_In;
  logic                  Data_Valid_In;
  logic                  Data_Ready_Out;
  logic                  Serial_Data_Out;
  logic                  Serial_Valid_Out;
  logic                  Frame_Start_Out;
  logic                  Frame_Last_Out;
  logic                  Busy_Out;

  modport master (
    output Parallel_Data_In,
    output Data_Valid_In,
    input  Data_Ready_Out,
    input  Serial_Data_Out,
    input  Serial_Valid_Out,
    input  Frame_Start_Out,
    input  Frame_Last_Out,
    input  Busy_Out
  );

  modport slave (
    input  Parallel_Data_In,
    input  Data_Valid_In,
    output Data_Ready_Out,
    output Serial_Data_Out,
    output Serial_Valid_Out,
    output Frame_Start_Out,
    output Frame_Last_Out,
    output Busy_Out
  );

endinterface

// File: rtl/piso_bit_counter.sv
// Bit-position counter for the serializer: enabled increment, synchronous
// clear with priority over increment, and a terminal-count flag.
module piso_bit_counter #(
  parameter int          CNT_W    = 5,
  parameter int unsigned TERMINAL = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] count_o,
  output logic             terminal_o
);

  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (here via the final else); a missing branch would infer a latch.
  always_comb begin
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end else begin
      count_d = count_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o    = count_q;
  assign terminal_o = (count_q == CNT_W'(TERMINAL));

endmodule

// File: rtl/parallel_in_serial_out_piso_tx.sv
// Word-level serializer: takes a parallel word on a valid/ready handshake and
// shifts it out one bit per enabled clock with start/last frame markers.
module parallel_in_serial_out_piso_tx
  import piso_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic Clk_In,
  input  logic Reset_In,
  input  logic Enable_In,
  parallel_in_serial_out_piso_tx_if.slave bus
);

  localparam int CNT_W = cnt_width(DATA_WIDTH);

  state_e                state_q;
  state_e                state_d;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_d;
  logic [CNT_W-1:0]      count;
  logic                  last_bit;
  logic                  in_shift;
  logic                  ready;
  logic                  accept;
  logic                  cnt_en;
  logic                  cnt_clr;

  logic                  serial_data;
  logic                  serial_valid;
  logic                  frame_start;
  logic                  frame_last;
  logic                  busy;

  assign in_shift = (state_q == SHIFT);

  // Ready is also masked by reset so nothing is offered while it is held.
  assign ready  = Enable_In & ~Reset_In & (~in_shift | last_bit);
  assign accept = bus.Data_Valid_In & ready;

  // The counter steps through the word; it clears on a new word and when the
  // frame ends, so an idle block always sits at count 0.
  assign cnt_en  = Enable_In & in_shift;
  assign cnt_clr = accept | (Enable_In & in_shift & last_bit);

  piso_bit_counter #(
    .CNT_W    (CNT_W),
    .TERMINAL (DATA_WIDTH - 1)
  ) u_bit_counter (
    .clk        (Clk_In),
    .rst        (Reset_In),
    .en         (cnt_en),
    .clr        (cnt_clr),
    .count_o    (count),
    .terminal_o (last_bit)
  );

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (Enable_In) begin
      unique case (state_q)
        IDLE:    if (accept) state_d = SHIFT;
        SHIFT:   if (last_bit && !accept) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // A reload wins over the shift so back-to-back words leave no gap.
  always_comb begin
    shift_d = shift_q;
    if (accept) begin
      shift_d = bus.Parallel_Data_In;
    end else if (Enable_In && in_shift) begin
      if (MSB_FIRST) begin
        shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
      end else begin
        shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  always_comb begin
    serial_data  = MSB_FIRST ? shift_q[DATA_WIDTH-1] : shift_q[0];
    serial_valid = Enable_In & in_shift;
    frame_start  = serial_valid & (count == '0);
    frame_last   = serial_valid & last_bit;
    busy         = in_shift;
  end

  assign bus.Data_Ready_Out   = ready;
  assign bus.Serial_Data_Out  = serial_data;
  assign bus.Serial_Valid_Out = serial_valid;
  assign bus.Frame_Start_Out  = frame_start;
  assign bus.Frame_Last_Out   = frame_last;
  assign bus.Busy_Out         = busy;

endmodule

// File: tb/tb_parallel_in_serial_out_piso_tx.sv
// Directed bench for the PISO transmitter: an MSB-first instance for most
// scenarios and an LSB-first instance for bit ordering.
module tb_parallel_in_serial_out_piso_tx;

  localparam int W = 32;

  logic clk;
  logic rst;
  logic enable;
  int   errors;
  int   checks;

  parallel_in_serial_out_piso_tx_if #(.DATA_WIDTH(W)) bus_a ();
  parallel_in_serial_out_piso_tx_if #(.DATA_WIDTH(W)) bus_b ();

  parallel_in_serial_out_piso_tx #(.DATA_WIDTH(W), .MSB_FIRST(1'b1)) dut_a (
    .Clk_In    (clk),
    .Reset_In  (rst),
    .Enable_In (enable),
    .bus       (bus_a)
  );

  parallel_in_serial_out_piso_tx #(.DATA_WIDTH(W), .MSB_FIRST(1'b0)) dut_b (
    .Clk_In    (clk),
    .Reset_In  (rst),
    .Enable_In (enable),
    .bus       (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {ready, serial_valid, frame_start, frame_last, serial_data}
  function automatic logic [4:0] obs_a();
    return {bus_a.Data_Ready_Out, bus_a.Serial_Valid_Out, bus_a.Frame_Start_Out,
            bus_a.Frame_Last_Out, bus_a.Serial_Data_Out};
  endfunction

  function automatic logic [4:0] obs_b();
    return {bus_b.Data_Ready_Out, bus_b.Serial_Valid_Out, bus_b.Frame_Start_Out,
            bus_b.Frame_Last_Out, bus_b.Serial_Data_Out};
  endfunction

  function automatic logic [4:0] exp_vec(input logic rdy, input int i, input logic bit_v);
    return {rdy, 1'b1, (i == 0) ? 1'b1 : 1'b0, (i == W - 1) ? 1'b1 : 1'b0, bit_v};
  endfunction

  initial begin
    logic [W-1:0] word;
    logic [W-1:0] word2;
    logic         seen_last;
    logic         held_bit;

    errors = 0;
    checks = 0;
    rst    = 1'b1;
    enable = 1'b0;
    bus_a.Parallel_Data_In = '0;
    bus_a.Data_Valid_In    = 1'b0;
    bus_b.Parallel_Data_In = '0;
    bus_b.Data_Valid_In    = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset_a_outputs", 64'(obs_a()), 64'h0);
    check("reset_a_busy", 64'(bus_a.Busy_Out), 64'h0);
    check("reset_b_outputs", 64'(obs_b()), 64'h0);
    rst    = 1'b0;
    enable = 1'b1;
    #1;
    check("ready_after_reset", 64'(bus_a.Data_Ready_Out), 64'h1);

    // Single word, MSB first
    @(negedge clk);
    word = 32'hA5A5_0F0F;
    bus_a.Parallel_Data_In = word;
    bus_a.Data_Valid_In    = 1'b1;
    @(negedge clk);
    bus_a.Data_Valid_In = 1'b0;
    for (int i = 0; i < W; i++) begin
      check($sformatf("single_bit%0d", i), 64'(obs_a()),
            64'(exp_vec(i == W - 1, i, word[W-1-i])));
      @(negedge clk);
    end
    check("single_idle_busy", 64'(bus_a.Busy_Out), 64'h0);
    check("single_idle_valid", 64'(bus_a.Serial_Valid_Out), 64'h0);

    // Back-to-back words with no gap
    bus_a.Parallel_Data_In = 32'hFFFF_FFFF;
    bus_a.Data_Valid_In    = 1'b1;
    @(negedge clk);
    bus_a.Parallel_Data_In = 32'h0000_0000;
    for (int i = 0; i < 2 * W; i++) begin
      check($sformatf("b2b_bit%0d", i), 64'(obs_a()),
            64'(exp_vec((i % W) == W - 1, i % W, (i < W) ? 1'b1 : 1'b0)));
      if (i == W) bus_a.Data_Valid_In = 1'b0;
      @(negedge clk);
    end
    check("b2b_idle_busy", 64'(bus_a.Busy_Out), 64'h0);

    // Enable pause after bit 10
    word = 32'h8000_0001;
    bus_a.Parallel_Data_In = word;
    bus_a.Data_Valid_In    = 1'b1;
    @(negedge clk);
    bus_a.Data_Valid_In = 1'b0;
    for (int i = 0; i < W; i++) begin
      check($sformatf("pause_bit%0d", i), 64'(obs_a()),
            64'(exp_vec(i == W - 1, i, word[W-1-i])));
      if (i == 9) begin
        held_bit = word[W-1-i];
        enable   = 1'b0;
        for (int p = 0; p < 3; p++) begin
          @(negedge clk);
          check($sformatf("pause_frozen%0d", p), 64'(obs_a()), 64'({4'b0000, held_bit}));
          check($sformatf("pause_busy%0d", p), 64'(bus_a.Busy_Out), 64'h1);
        end
        enable = 1'b1;
      end
      @(negedge clk);
    end
    check("pause_idle_busy", 64'(bus_a.Busy_Out), 64'h0);

    // Reset in the middle of a frame
    word = 32'h1234_5678;
    bus_a.Parallel_Data_In = word;
    bus_a.Data_Valid_In    = 1'b1;
    @(negedge clk);
    bus_a.Data_Valid_In = 1'b0;
    seen_last = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("midrst_bit%0d", i), 64'(obs_a()), 64'(exp_vec(1'b0, i, word[W-1-i])));
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    check("midrst_outputs", 64'(obs_a()), 64'h0);
    check("midrst_busy", 64'(bus_a.Busy_Out), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_ready", 64'(bus_a.Data_Ready_Out), 64'h1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_a.Frame_Last_Out !== 1'b0) seen_last = 1'b1;
    end
    check("midrst_no_last", 64'(seen_last), 64'h0);

    // Valid ignored while busy; second word taken on the last bit
    word  = 32'h0000_FFFF;
    word2 = 32'hDEAD_BEEF;
    bus_a.Parallel_Data_In = word;
    bus_a.Data_Valid_In    = 1'b1;
    @(negedge clk);
    bus_a.Parallel_Data_In = word2;
    for (int i = 0; i < W; i++) begin
      check($sformatf("busy_first_bit%0d", i), 64'(obs_a()),
            64'(exp_vec(i == W - 1, i, word[W-1-i])));
      @(negedge clk);
    end
    bus_a.Data_Valid_In = 1'b0;
    for (int i = 0; i < W; i++) begin
      check($sformatf("busy_second_bit%0d", i), 64'(obs_a()),
            64'(exp_vec(i == W - 1, i, word2[W-1-i])));
      @(negedge clk);
    end
    check("busy_idle_busy", 64'(bus_a.Busy_Out), 64'h0);

    // LSB-first ordering
    word = 32'h0000_0001;
    bus_b.Parallel_Data_In = word;
    bus_b.Data_Valid_In    = 1'b1;
    @(negedge clk);
    bus_b.Data_Valid_In = 1'b0;
    for (int i = 0; i < W; i++) begin
      check($sformatf("lsb_bit%0d", i), 64'(obs_b()), 64'(exp_vec(i == W - 1, i, word[i])));
      @(negedge clk);
    end
    check("lsb_idle_busy", 64'(bus_b.Busy_Out), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
